imm_ext_pipe: RTL and testbench

- Pipelined, parametrised successor to the combinational immediate sign-extender.
- Decodes the LEGv8 immediate formats D, CB, B, I and IW, and produces an N-bit extended immediate with a format tag.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so it can sit between the fetch/IF-ID register and the decode stage of the pipelined core.
- Optional pre-shifting of branch offsets and a synchronous flush for branch mispredict.

---
 rtl/imm_ext_pipe.sv | 157 +++++++++++++++
 tb/tb_imm_ext_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Decodes LEGv8 D/CB/B/I/IW immediates to N bits with a format tag and an IW range error flag.
// Latency: 1 cycle from accept to out_valid when empty; sustains 1 word/cycle while out_ready=1.
// Backpressure: 2-entry skid (OR + SK); in_ready is registered and drops only when both are occupied.
module imm_ext_pipe #(
    parameter int N            = 64,
    parameter bit SHIFT_BRANCH = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] imm,
    output logic [2:0]   fmt,
    output logic         err
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_D    = 3'd1;
    localparam logic [2:0] FMT_CB   = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_I    = 3'd4;
    localparam logic [2:0] FMT_IW   = 3'd5;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [7:0] N_W = 8'(N);

    typedef struct packed {
        logic [N-1:0] imm;
        logic [2:0]   fmt;
        logic         err;
    } ent_t;

    ent_t       dec;
    ent_t       or_q;
    ent_t       sk_q;
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       in_ready_q;
    logic       accept;
    logic       pop;
    logic       load_or;
    logic       load_sk;
    logic       or_from_sk;

    logic [N-1:0] cb_ext;
    logic [N-1:0] b_ext;
    logic [N-1:0] iw_base;
    logic [7:0]   iw_top;
    logic [4:0]   unused_instr;

    // Rd/Rt field carries no immediate bits in any supported format.
    assign unused_instr = instr[4:0];

    assign cb_ext  = {{(N-19){instr[23]}}, instr[23:5]};
    assign b_ext   = {{(N-26){instr[25]}}, instr[25:0]};
    assign iw_base = {{(N-16){1'b0}}, instr[20:5]};
    assign iw_top  = {2'b00, instr[22:21], 4'b0000} + 8'd16;

    always_comb begin
        dec = '0;
        if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
            dec.fmt = FMT_D;
            dec.imm = {{(N-9){instr[20]}}, instr[20:12]};
        end else if (instr[31:25] == 7'b1011010) begin
            dec.fmt = FMT_CB;
            dec.imm = SHIFT_BRANCH ? (cb_ext << 2) : cb_ext;
        end else if (instr[30:26] == 5'b00101) begin
            dec.fmt = FMT_B;
            dec.imm = SHIFT_BRANCH ? (b_ext << 2) : b_ext;
        end else if (instr[31] && instr[28:22] == 7'b1000100) begin
            dec.fmt = FMT_I;
            dec.imm = {{(N-12){1'b0}}, instr[21:10]};
        end else if (instr[31:23] == 9'b110100101) begin
            dec.fmt = FMT_IW;
            // A halfword slot that lands beyond the top of the result is reported, not truncated.
            if (iw_top > N_W) begin
                dec.err = 1'b1;
            end else begin
                dec.imm = iw_base << {instr[22:21], 4'b0000};
            end
        end else begin
            dec.fmt = FMT_NONE;
        end
    end

    assign out_valid = (state != EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nxt  = state;
        load_or    = 1'b0;
        load_sk    = 1'b0;
        or_from_sk = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_or   = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_or = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_sk   = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt  = ONE;
                    load_or    = 1'b1;
                    or_from_sk = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
            or_q       <= '0;
            sk_q       <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
            if (!flush) begin
                if (load_or) begin
                    or_q <= or_from_sk ? sk_q : dec;
                end
                if (load_sk) begin
                    sk_q <= dec;
                end
            end
        end
    end

    assign imm = or_q.imm;
    assign fmt = or_q.fmt;
    assign err = or_q.err;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: three instances (N=64, N=64 with branch pre-shift, N=32) share stimulus.
module tb_imm_ext_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        out_ready = 1'b0;

    logic        r64, v64, e64;
    logic [63:0] i64;
    logic [2:0]  f64;
    logic        r64s, v64s, e64s;
    logic [63:0] i64s;
    logic [2:0]  f64s;
    logic        r32, v32, e32;
    logic [31:0] i32;
    logic [2:0]  f32;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [31:0] W_LDUR = 32'hF85F8041;
    localparam logic [31:0] W_CBZ  = 32'hB4FFFF83;
    localparam logic [31:0] W_B    = 32'h16000000;
    localparam logic [31:0] W_ADDI = 32'h913FFC00;
    localparam logic [31:0] W_MOVZ = 32'hD2F7DDE0;
    localparam logic [31:0] W_ADD  = 32'h8B020020;

    always #5 clk = ~clk;

    imm_ext_pipe #(.N(64), .SHIFT_BRANCH(1'b0)) u64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r64),
        .instr(instr), .out_valid(v64), .out_ready(out_ready), .imm(i64), .fmt(f64), .err(e64));
    imm_ext_pipe #(.N(64), .SHIFT_BRANCH(1'b1)) u64s (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r64s),
        .instr(instr), .out_valid(v64s), .out_ready(out_ready), .imm(i64s), .fmt(f64s), .err(e64s));
    imm_ext_pipe #(.N(32), .SHIFT_BRANCH(1'b0)) u32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .instr(instr), .out_valid(v32), .out_ready(out_ready), .imm(i32), .fmt(f32), .err(e32));

    // Presents one word with out_ready=1 and returns at the negedge after it was accepted.
    task automatic send_one(input logic [31:0] w);
        @(negedge clk);
        in_valid  = 1'b1;
        instr     = w;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        total_cnt++; if ({v64, i64, f64, e64} !== 69'd0) $display("FAIL reset_outputs got v=%b imm=%h fmt=%0d err=%b want all 0", v64, i64, f64, e64); else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (r64 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", r64); else pass_cnt++;
        total_cnt++; if (v64 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", v64); else pass_cnt++;
    endtask

    task automatic test_d;
        send_one(W_LDUR);
        total_cnt++; if (v64 !== 1'b1) $display("FAIL d_valid got %b want 1", v64); else pass_cnt++;
        total_cnt++; if (i64 !== 64'hFFFFFFFFFFFFFFF8) $display("FAIL d_imm got %h want FFFFFFFFFFFFFFF8", i64); else pass_cnt++;
        total_cnt++; if (f64 !== 3'd1 || e64 !== 1'b0) $display("FAIL d_fmt got fmt=%0d err=%b want 1/0", f64, e64); else pass_cnt++;
        total_cnt++; if (i32 !== 32'hFFFFFFF8) $display("FAIL d_imm32 got %h want FFFFFFF8", i32); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (v64 !== 1'b0) $display("FAIL d_drain got %b want 0", v64); else pass_cnt++;
    endtask

    task automatic test_cb;
        send_one(W_CBZ);
        total_cnt++; if (i64 !== 64'hFFFFFFFFFFFFFFFC || f64 !== 3'd2) $display("FAIL cb_imm got %h fmt=%0d want FFFFFFFFFFFFFFFC/2", i64, f64); else pass_cnt++;
        total_cnt++; if (i64s !== 64'hFFFFFFFFFFFFFFF0) $display("FAIL cb_shift got %h want FFFFFFFFFFFFFFF0", i64s); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_b;
        send_one(W_B);
        total_cnt++; if (i64 !== 64'hFFFFFFFFFE000000 || f64 !== 3'd3) $display("FAIL b_imm got %h fmt=%0d want FFFFFFFFFE000000/3", i64, f64); else pass_cnt++;
        total_cnt++; if (i64s !== 64'hFFFFFFFFF8000000) $display("FAIL b_shift got %h want FFFFFFFFF8000000", i64s); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_i;
        send_one(W_ADDI);
        total_cnt++; if (i64 !== 64'h0000000000000FFF || f64 !== 3'd4) $display("FAIL i_imm got %h fmt=%0d want 0000000000000FFF/4", i64, f64); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_iw;
        send_one(W_MOVZ);
        total_cnt++; if (i64 !== 64'hBEEF000000000000 || f64 !== 3'd5 || e64 !== 1'b0) $display("FAIL iw_imm got %h fmt=%0d err=%b want BEEF000000000000/5/0", i64, f64, e64); else pass_cnt++;
        total_cnt++; if (i32 !== 32'h0 || e32 !== 1'b1 || f32 !== 3'd5) $display("FAIL iw_n32 got %h err=%b fmt=%0d want 0/1/5", i32, e32, f32); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_none;
        send_one(W_ADD);
        total_cnt++; if (v64 !== 1'b1) $display("FAIL none_slot got valid=%b want 1", v64); else pass_cnt++;
        total_cnt++; if (i64 !== 64'h0 || f64 !== 3'd0 || e64 !== 1'b0) $display("FAIL none_imm got %h fmt=%0d err=%b want 0/0/0", i64, f64, e64); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = W_LDUR;
        @(negedge clk);
        total_cnt++; if (v64 !== 1'b1 || r64 !== 1'b1) $display("FAIL bp_a_accept got v=%b r=%b want 1/1", v64, r64); else pass_cnt++;
        instr = W_ADDI;
        @(negedge clk);
        total_cnt++; if (r64 !== 1'b0) $display("FAIL bp_full_ready got %b want 0", r64); else pass_cnt++;
        instr = W_MOVZ;
        @(negedge clk);
        total_cnt++; if (r64 !== 1'b0 || i64 !== 64'hFFFFFFFFFFFFFFF8 || f64 !== 3'd1) $display("FAIL bp_hold got r=%b imm=%h fmt=%0d want 0/FFFFFFFFFFFFFFF8/1", r64, i64, f64); else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if (v64 !== 1'b1 || i64 !== 64'h0000000000000FFF || f64 !== 3'd4) $display("FAIL bp_second got v=%b imm=%h fmt=%0d want 1/0000000000000FFF/4", v64, i64, f64); else pass_cnt++;
        total_cnt++; if (r64 !== 1'b1) $display("FAIL bp_ready_back got %b want 1", r64); else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++; if (v64 !== 1'b1 || i64 !== 64'hBEEF000000000000 || f64 !== 3'd5) $display("FAIL bp_third got v=%b imm=%h fmt=%0d want 1/BEEF000000000000/5", v64, i64, f64); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (v64 !== 1'b0) $display("FAIL bp_no_dup got valid=%b want 0", v64); else pass_cnt++;
    endtask

    task automatic test_flush;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = W_LDUR;
        @(negedge clk);
        instr = W_ADDI;
        @(negedge clk);
        total_cnt++; if (r64 !== 1'b0 || v64 !== 1'b1) $display("FAIL fl_full got r=%b v=%b want 0/1", r64, v64); else pass_cnt++;
        flush = 1'b1;
        instr = W_MOVZ;
        @(negedge clk);
        total_cnt++; if (v64 !== 1'b0 || r64 !== 1'b1) $display("FAIL fl_empty got v=%b r=%b want 0/1", v64, r64); else pass_cnt++;
        instr = W_CBZ;
        @(negedge clk);
        total_cnt++; if (v64 !== 1'b0) $display("FAIL fl_drop_accept got valid=%b want 0", v64); else pass_cnt++;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if (v64 !== 1'b0) $display("FAIL fl_never_appears got valid=%b want 0", v64); else pass_cnt++;
        send_one(W_B);
        total_cnt++; if (v64 !== 1'b1 || f64 !== 3'd3 || i64 !== 64'hFFFFFFFFFE000000) $display("FAIL fl_resume got v=%b fmt=%0d imm=%h want 1/3/FFFFFFFFFE000000", v64, f64, i64); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = W_MOVZ;
        @(negedge clk);
        total_cnt++; if (v64 !== 1'b1 || f64 !== 3'd5) $display("FAIL ar_loaded got v=%b fmt=%0d want 1/5", v64, f64); else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++; if (v64 !== 1'b0 || i64 !== 64'h0 || f64 !== 3'd0 || e64 !== 1'b0) $display("FAIL ar_async got v=%b imm=%h fmt=%0d err=%b want 0/0/0/0", v64, i64, f64, e64); else pass_cnt++;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (r64 !== 1'b1 || v64 !== 1'b0) $display("FAIL ar_recover got r=%b v=%b want 1/0", r64, v64); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_d();
        test_cb();
        test_b();
        test_i();
        test_iw();
        test_none();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
